// File: rtl/step_sequencer_if.sv
// Control, pattern and output bundle of the four-track step sequencer.
interface step_sequencer_if;
    logic        start;
    logic        stop;
    logic        pause;
    logic [1:0]  tempo_sel;
    logic [15:0] note1;
    logic [15:0] note2;
    logic [15:0] note3;
    logic [15:0] note4;
    logic [3:0]  step;
    logic [3:0]  trig;
    logic [3:0]  gate;
    logic        sound;
    logic        playing;
    logic        wrap;

    modport master (
        output start, stop, pause, tempo_sel,
        output note1, note2, note3, note4,
        input  step, trig, gate, sound, playing, wrap
    );

    modport slave (
        input  start, stop, pause, tempo_sel,
        input  note1, note2, note3, note4,
        output step, trig, gate, sound, playing, wrap
    );
endinterface

// File: rtl/step_sequencer.sv
// Four-track 16-step sequencer with per-track gated square-wave tones.
module step_sequencer #(
    parameter int STEP_TICKS = 6250000,
    parameter int GATE_TICKS = 3125000,
    parameter int TONE0      = 95556,
    parameter int TONE1      = 85131,
    parameter int TONE2      = 75843,
    parameter int TONE3      = 71586
) (
    input  logic            clk,
    input  logic            reset,
    step_sequencer_if.slave bus
);
    localparam int TMAX = (STEP_TICKS > GATE_TICKS) ? STEP_TICKS : GATE_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int NM01 = (TONE0 > TONE1) ? TONE0 : TONE1;
    localparam int NM23 = (TONE2 > TONE3) ? TONE2 : TONE3;
    localparam int NMAX = (NM01 > NM23) ? NM01 : NM23;
    localparam int CW   = $clog2(NMAX + 1);

    localparam logic [TW-1:0] STEP_W = TW'(STEP_TICKS);
    localparam logic [TW-1:0] GATE_W = TW'(GATE_TICKS);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] period_q, period_d;
    logic          pend_q, pend_d;
    logic [3:0]    bits_q, bits_d;
    logic [3:0]    tone_q, tone_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    trig_q, trig_d;
    logic [3:0]    gate_q, gate_d;
    logic          wrap_q, wrap_d;
    logic          begin_step;
    logic [TW-1:0] glen;

    function automatic logic [CW-1:0] tone_lim(input int i);
        logic [CW-1:0] r;
        unique case (i)
            0:       r = CW'(TONE0 - 1);
            1:       r = CW'(TONE1 - 1);
            2:       r = CW'(TONE2 - 1);
            default: r = CW'(TONE3 - 1);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tick_d     = tick_q;
        period_d   = period_q;
        pend_d     = pend_q;
        bits_d     = bits_q;
        tone_d     = tone_q;
        cnt_d      = cnt_q;
        trig_d     = '0;
        gate_d     = '0;
        wrap_d     = 1'b0;
        begin_step = 1'b0;
        glen       = '0;

        if (bus.stop) begin
            state_d = IDLE;
            step_d  = '0;
            tick_d  = '0;
            pend_d  = 1'b0;
            bits_d  = '0;
            tone_d  = '0;
            cnt_d   = '{default: '0};
        end else if (bus.start) begin
            state_d    = RUN;
            step_d     = '0;
            tick_d     = '0;
            pend_d     = 1'b0;
            begin_step = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (bus.pause)
                        state_d = PAUSE;
                    for (int i = 0; i < 4; i++) begin
                        if (cnt_q[i] == tone_lim(i)) begin
                            cnt_d[i]  = '0;
                            tone_d[i] = ~tone_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    if (tick_q == period_q - TW'(1)) begin
                        tick_d = '0;
                        step_d = step_q + 4'd1;
                        // An advance landing in PAUSE starts its step on resume
                        if (bus.pause) begin
                            pend_d = 1'b1;
                        end else begin
                            begin_step = 1'b1;
                            wrap_d     = (step_q == 4'd15);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                        if (pend_q) begin
                            begin_step = 1'b1;
                            pend_d     = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (begin_step) begin
            bits_d = {bus.note4[step_d], bus.note3[step_d],
                      bus.note2[step_d], bus.note1[step_d]};
            period_d = STEP_W >> bus.tempo_sel;
            tone_d   = '0;
            cnt_d    = '{default: '0};
            trig_d   = bits_d;
        end

        glen = (GATE_W < period_d) ? GATE_W : period_d;
        if (state_d == RUN)
            gate_d = bits_d & {4{tick_d < glen}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            tick_q   <= '0;
            period_q <= '0;
            pend_q   <= 1'b0;
            bits_q   <= '0;
            tone_q   <= '0;
            cnt_q    <= '{default: '0};
            trig_q   <= '0;
            gate_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            bits_q   <= bits_d;
            tone_q   <= tone_d;
            cnt_q    <= cnt_d;
            trig_q   <= trig_d;
            gate_q   <= gate_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.step    = step_q;
    assign bus.trig    = trig_q;
    assign bus.gate    = gate_q;
    assign bus.wrap    = wrap_q;
    assign bus.playing = (state_q != IDLE);
    assign bus.sound   = |(tone_q & gate_q);
endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer with small tick/tone parameters.
module tb_step_sequencer;
    typedef enum logic [2:0] {
        F_STEP, F_TRIG, F_GATE, F_SOUND, F_PLAY, F_WRAP
    } fld_t;

    typedef struct {
        int          cyc;
        fld_t        f;
        logic [3:0]  val;
        logic [95:0] nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   base;
    exp_t exp_q[$];
    exp_t e;

    step_sequencer_if bus();

    step_sequencer #(
        .STEP_TICKS(16),
        .GATE_TICKS(8),
        .TONE0(2),
        .TONE1(3),
        .TONE2(4),
        .TONE3(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] field_val(input fld_t f);
        logic [3:0] v;
        case (f)
            F_STEP:  v = bus.step;
            F_TRIG:  v = bus.trig;
            F_GATE:  v = bus.gate;
            F_SOUND: v = {3'b0, bus.sound};
            F_PLAY:  v = {3'b0, bus.playing};
            default: v = {3'b0, bus.wrap};
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation due at the current cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %0s: due cycle %0d, seen at %0d",
                         e.nm, e.cyc, cyc);
            end else if (field_val(e.f) !== e.val) begin
                errors++;
                $display("FAIL %0s @%0d: got %h, expected %h",
                         e.nm, cyc, field_val(e.f), e.val);
            end
        end
    end

    task automatic expect_at(input int r, input fld_t f,
                             input logic [3:0] v,
                             input logic [95:0] nm);
        exp_t x;
        int   k;
        x.cyc = base + r;
        x.f   = f;
        x.val = v;
        x.nm  = nm;
        k = exp_q.size();
        while (k > 0 && exp_q[k-1].cyc > x.cyc) k--;
        exp_q.insert(k, x);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int r);
        while (cyc < base + r) next();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        next();
        bus.stop = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.pause     = 1'b0;
        bus.tempo_sel = 2'd0;
        bus.note1     = '0;
        bus.note2     = '0;
        bus.note3     = '0;
        bus.note4     = '0;
        next();

        // Reset state
        base = cyc;
        expect_at(1, F_STEP,  4'd0, "rst_step");
        expect_at(1, F_TRIG,  4'd0, "rst_trig");
        expect_at(1, F_GATE,  4'd0, "rst_gate");
        expect_at(1, F_SOUND, 4'd0, "rst_sound");
        expect_at(1, F_PLAY,  4'd0, "rst_play");
        expect_at(1, F_WRAP,  4'd0, "rst_wrap");
        next();
        reset = 1'b0;
        next();

        // Single note on track 0, tone half-period 2
        bus.note1 = 16'h0001;
        base = cyc;
        expect_at(1,  F_STEP,  4'd0,    "a_step0");
        expect_at(1,  F_TRIG,  4'b0001, "a_trig");
        expect_at(1,  F_GATE,  4'b0001, "a_gate1");
        expect_at(1,  F_PLAY,  4'd1,    "a_play");
        expect_at(1,  F_WRAP,  4'd0,    "a_nowrap");
        expect_at(2,  F_TRIG,  4'd0,    "a_trig_off");
        expect_at(2,  F_SOUND, 4'd0,    "a_snd2");
        expect_at(3,  F_SOUND, 4'd1,    "a_snd3");
        expect_at(4,  F_SOUND, 4'd1,    "a_snd4");
        expect_at(5,  F_SOUND, 4'd0,    "a_snd5");
        expect_at(7,  F_SOUND, 4'd1,    "a_snd7");
        expect_at(8,  F_GATE,  4'b0001, "a_gate8");
        expect_at(9,  F_GATE,  4'd0,    "a_gate9");
        expect_at(9,  F_SOUND, 4'd0,    "a_snd9");
        expect_at(16, F_STEP,  4'd0,    "a_step16");
        expect_at(17, F_STEP,  4'd1,    "a_step17");
        expect_at(17, F_TRIG,  4'd0,    "a_notrig");
        expect_at(21, F_PLAY,  4'd0,    "a_stop_pl");
        expect_at(21, F_STEP,  4'd0,    "a_stop_st");
        expect_at(21, F_GATE,  4'd0,    "a_stop_gt");
        pulse_start();
        run_to(5);
        bus.note1 = 16'h0000;
        run_to(20);
        pulse_stop();
        run_to(24);

        // All tracks, full cycle through wrap
        bus.note1 = 16'hFFFF;
        bus.note2 = 16'hFFFF;
        bus.note3 = 16'hFFFF;
        bus.note4 = 16'hFFFF;
        base = cyc;
        for (int k = 0; k < 16; k++)
            expect_at(1 + 16 * k, F_TRIG, 4'b1111, "b_trig");
        expect_at(1,   F_WRAP, 4'd0,    "b_wrap_st");
        expect_at(2,   F_TRIG, 4'd0,    "b_trig_off");
        expect_at(8,   F_GATE, 4'b1111, "b_gate8");
        expect_at(9,   F_GATE, 4'd0,    "b_gate9");
        expect_at(256, F_STEP, 4'd15,   "b_step15");
        expect_at(256, F_WRAP, 4'd0,    "b_wrap_pre");
        expect_at(257, F_STEP, 4'd0,    "b_step0");
        expect_at(257, F_WRAP, 4'd1,    "b_wrap");
        expect_at(257, F_TRIG, 4'b1111, "b_trig_wr");
        expect_at(258, F_WRAP, 4'd0,    "b_wrap_post");
        pulse_start();
        run_to(260);
        pulse_stop();
        run_to(263);

        // Pause for 10 cycles with the tick held at 5
        bus.note2 = '0;
        bus.note3 = '0;
        bus.note4 = '0;
        bus.note1 = 16'h0001;
        base = cyc;
        expect_at(5,  F_GATE,  4'b0001, "c_gate5");
        expect_at(6,  F_GATE,  4'd0,    "c_pgate");
        expect_at(6,  F_PLAY,  4'd1,    "c_pplay");
        expect_at(10, F_STEP,  4'd0,    "c_pstep");
        expect_at(10, F_SOUND, 4'd0,    "c_psound");
        expect_at(10, F_TRIG,  4'd0,    "c_ptrig");
        expect_at(15, F_GATE,  4'd0,    "c_gate15");
        expect_at(16, F_GATE,  4'b0001, "c_resume");
        expect_at(16, F_SOUND, 4'd0,    "c_snd16");
        expect_at(17, F_SOUND, 4'd1,    "c_snd17");
        expect_at(18, F_GATE,  4'b0001, "c_gate18");
        expect_at(19, F_GATE,  4'd0,    "c_gate19");
        expect_at(26, F_STEP,  4'd0,    "c_step26");
        expect_at(27, F_STEP,  4'd1,    "c_step27");
        pulse_start();
        run_to(5);
        bus.pause = 1'b1;
        repeat (10) next();
        bus.pause = 1'b0;
        run_to(30);
        pulse_stop();
        run_to(32);

        // Restart during step 7, then start+stop together
        bus.note1 = 16'hFFFF;
        base = cyc;
        expect_at(114, F_STEP, 4'd7,    "d_step7");
        expect_at(115, F_TRIG, 4'd0,    "d_trig115");
        expect_at(116, F_STEP, 4'd0,    "d_restart");
        expect_at(116, F_TRIG, 4'b0001, "d_retrig");
        expect_at(116, F_GATE, 4'b0001, "d_regate");
        expect_at(121, F_PLAY, 4'd0,    "d_ss_play");
        expect_at(121, F_STEP, 4'd0,    "d_ss_step");
        expect_at(121, F_TRIG, 4'd0,    "d_ss_trig");
        expect_at(125, F_PLAY, 4'd0,    "d_idle");
        pulse_start();
        run_to(115);
        pulse_start();
        run_to(120);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        next();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        run_to(126);

        // Tempo change mid-step takes effect at the next step
        base = cyc;
        expect_at(9,  F_GATE, 4'd0,    "e_gate9");
        expect_at(16, F_STEP, 4'd0,    "e_step16");
        expect_at(17, F_STEP, 4'd1,    "e_step17");
        expect_at(17, F_TRIG, 4'b0001, "e_trig17");
        expect_at(20, F_STEP, 4'd1,    "e_step20");
        expect_at(20, F_GATE, 4'b0001, "e_gate20");
        expect_at(21, F_STEP, 4'd2,    "e_step21");
        expect_at(21, F_TRIG, 4'b0001, "e_trig21");
        expect_at(25, F_STEP, 4'd3,    "e_step25");
        pulse_start();
        run_to(5);
        bus.tempo_sel = 2'd2;
        run_to(27);
        pulse_stop();
        bus.tempo_sel = 2'd0;
        run_to(29);

        // Reset during step 9 with gate high
        base = cyc;
        expect_at(147, F_STEP,  4'd9,    "f_step9");
        expect_at(147, F_GATE,  4'b0001, "f_gate");
        expect_at(148, F_STEP,  4'd0,    "f_r_step");
        expect_at(148, F_TRIG,  4'd0,    "f_r_trig");
        expect_at(148, F_GATE,  4'd0,    "f_r_gate");
        expect_at(148, F_SOUND, 4'd0,    "f_r_sound");
        expect_at(148, F_PLAY,  4'd0,    "f_r_play");
        expect_at(148, F_WRAP,  4'd0,    "f_r_wrap");
        expect_at(155, F_PLAY,  4'd0,    "f_idle_pl");
        expect_at(155, F_STEP,  4'd0,    "f_idle_st");
        expect_at(155, F_GATE,  4'd0,    "f_idle_gt");
        pulse_start();
        run_to(147);
        reset = 1'b1;
        next();
        reset = 1'b0;
        run_to(157);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %0s: never checked (due %0d)", e.nm, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
